// File: rtl/tt_seq_pkg.sv
// Shared types and sizes for the truth-table sequencer and its comparator.
package tt_seq_pkg;
  localparam int IDX_W = 2;
  localparam int TT_W  = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;
endpackage

// File: rtl/tt_seq_cmp.sv
// Dual 4-bit table comparator; only instantiated when TT_SEQ_COMPARE_EN is defined.
module tt_seq_cmp
  import tt_seq_pkg::*;
(
  input  logic [TT_W-1:0] tt1,
  input  logic [TT_W-1:0] tt2,
  input  logic [TT_W-1:0] exp1,
  input  logic [TT_W-1:0] exp2,
  output logic            match
);
  assign match = (tt1 == exp1) && (tt2 == exp2);
endmodule

// File: rtl/tt_sequencer.sv
// Sweeps a 2-input function unit through 00,01,10,11 and captures both outputs
// as 4-bit truth tables. Optional table compare under macro TT_SEQ_COMPARE_EN.
//
// state  | meaning
// IDLE   | waiting for start; tables hold last sweep
// SETTLE | x_o/y_o driven, counting down SETTLE_CYCLES
// SAMPLE | capture s1_i/s2_i into tt1/tt2 at idx
// DONE   | one-cycle completion pulse, idx returns to 0
module tt_sequencer
  import tt_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            x_o,
  output logic            y_o,
  input  logic            s1_i,
  input  logic            s2_i,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt1,
  output logic [TT_W-1:0] tt2,
  input  logic [TT_W-1:0] exp1,
  input  logic [TT_W-1:0] exp2,
  output logic            match
);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(TT_W - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TT_W-1:0]   tt1_q, tt1_d;
  logic [TT_W-1:0]   tt2_q, tt2_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt1_d   = tt1_q;
    tt2_d   = tt2_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tt1_d   = '0;
          tt2_d   = '0;
          idx_d   = '0;
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // terminal count at 1 gives exactly SETTLE_CYCLES cycles in this state
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SAMPLE: begin
        tt1_d[idx_q] = s1_i;
        tt2_d[idx_q] = s2_i;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tt1_q   <= '0;
      tt2_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt1_q   <= tt1_d;
      tt2_q   <= tt2_d;
    end
  end

  assign x_o  = idx_q[1];
  assign y_o  = idx_q[0];
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign tt1  = tt1_q;
  assign tt2  = tt2_q;

`ifdef TT_SEQ_COMPARE_EN
  logic cmp_match;
  logic match_q, match_d;

  tt_seq_cmp u_cmp (
    .tt1   (tt1_q),
    .tt2   (tt2_q),
    .exp1  (exp1),
    .exp2  (exp2),
    .match (cmp_match)
  );

  // tables are complete by DONE, so the result latches there and holds
  always_comb begin
    match_d = match_q;
    if (state_q == IDLE && start) match_d = 1'b0;
    else if (state_q == DONE)     match_d = cmp_match;
  end

  always_ff @(posedge clk) begin
    if (reset) match_q <= 1'b0;
    else       match_q <= match_d;
  end

  assign match = match_q;
`else
  logic unused_exp;
  assign unused_exp = ^{exp1, exp2};
  assign match      = 1'b0;
`endif
endmodule

// File: doc/tt_sequencer.md
TT_SEQUENCER -- requirements
Module: tt_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: wait cycles (1..15) between driving an input pair and sampling outputs.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one full truth-table sweep; sampled only in IDLE.
REQ-005 x_o  output  1  registered x drive to the 2-input function unit.
REQ-006 y_o  output  1  registered y drive to the 2-input function unit.
REQ-007 s1_i  input  1  function unit output s1 (combinational from x_o/y_o).
REQ-008 s2_i  input  1  function unit output s2.
REQ-009 busy  output  1  high from the cycle after start is accepted until DONE exits.
REQ-010 done  output  1  one-cycle pulse when the sweep completes.
REQ-011 tt1  output  4  captured s1 truth table; bit i = s1 at input index i.
REQ-012 tt2  output  4  captured s2 truth table; bit i = s2 at input index i.
REQ-013 exp1, exp2  input  4 each  expected tables (used only with TT_SEQ_COMPARE_EN).
REQ-014 match  output  1  high when tt1==exp1 and tt2==exp2 after a sweep.

Function
REQ-015 FSM states IDLE, SETTLE, SAMPLE, DONE, stored in a registered state variable.
REQ-016 Input index idx is 2 bits; x_o = idx[1], y_o = idx[0]; sweep order 00, 01, 10, 11.
REQ-017 IDLE with start=1: clear tt1/tt2 to 0, set idx=0, load settle counter, go SETTLE.
REQ-018 SETTLE holds x_o/y_o stable for exactly SETTLE_CYCLES cycles, then goes SAMPLE.
REQ-019 SAMPLE writes s1_i into tt1[idx] and s2_i into tt2[idx] in the same cycle.
REQ-020 SAMPLE with idx<3: increment idx, reload counter, go SETTLE; with idx==3: go DONE.
REQ-021 idx never wraps during a sweep; after DONE, idx returns to 0.
REQ-022 DONE lasts one cycle: done=1, busy=0 on the next cycle, return to IDLE.
REQ-023 Latency: start accepted at cycle T -> done high at cycle T+4*(SETTLE_CYCLES+1)+1 (T+9 for the default).
REQ-024 start while busy is ignored; no queuing; start held high in IDLE after DONE begins a new sweep.
REQ-025 tt1/tt2 hold their values after DONE until the next accepted start.

Reset
REQ-026 reset=1 forces state=IDLE, idx=0, x_o=0, y_o=0, busy=0, done=0, tt1=0, tt2=0, match=0, counter=0.
REQ-027 Reset mid-sweep aborts immediately; no done pulse; partial tables are discarded (cleared).
REQ-028 Reset has priority over start in the same cycle.

Configuration
REQ-029 Macro TT_SEQ_COMPARE_EN defined: match is registered in DONE as (tt1==exp1)&&(tt2==exp2), including the final sample, and holds until the next start or reset.
REQ-030 Macro TT_SEQ_COMPARE_EN undefined: no compare logic; match tied to 0; exp1/exp2 unused.

Structure
REQ-031 Shared package tt_seq_pkg holds the state encoding (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3), IDX_W=2, TT_W=4, and the settle counter width (4).
REQ-032 One sub-module tt_seq_cmp (4-bit dual-table comparator), instantiated only under TT_SEQ_COMPARE_EN.
REQ-033 The function unit is external; the bench connects s1_i/s2_i to it.

Verification
REQ-034 Function s1=s2=~x&y, start pulse at T -> done at T+9, tt1=4'b0010, tt2=4'b0010.
REQ-035 With the macro, exp1=exp2=4'b0010 -> match=1; exp1=4'b0100 -> match=0.
REQ-036 SETTLE_CYCLES=3, start at T -> done at T+17; x_o/y_o are stable for 3 cycles before each sample.
REQ-037 start pulsed again at T+4 mid-sweep -> ignored; done at T+9 only, single pulse.
REQ-038 reset asserted at T+5 -> next cycle all outputs 0 and state IDLE; no done; a new start then gives a full correct sweep.
REQ-039 start held high continuously -> back-to-back sweeps; done pulses every 10 cycles (default), with tables cleared at each accept.
